// File: rtl/direction_arbiter_if.sv
// Button pulses into the direction arbiter and its registered heading/status outputs.
interface direction_arbiter_if;
  logic       BtnUp;
  logic       BtnRight;
  logic       BtnDown;
  logic       BtnLeft;
  logic       BtnPause;
  logic [1:0] Direction;
  logic       Tick;
  logic       Running;
  logic       Paused;
  logic [1:0] Pending;

  modport master (
    output BtnUp, BtnRight, BtnDown, BtnLeft, BtnPause,
    input  Direction, Tick, Running, Paused, Pending
  );

  modport slave (
    input  BtnUp, BtnRight, BtnDown, BtnLeft, BtnPause,
    output Direction, Tick, Running, Paused, Pending
  );
endinterface

// File: rtl/direction_arbiter.sv
// Game-step tick generator with a 2-deep queue of legal heading changes,
// committed one per tick; IDLE/RUN/PAUSED control via button pulses.
module direction_arbiter #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input logic                  Clock,
  input logic                  Reset,
  direction_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] WRAP_VAL = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [1:0]       dir_q;
  logic             tick_q;
  logic             running_q;
  logic             paused_q;
  logic [1:0]       pending_q;
  logic [1:0]       q0;
  logic [1:0]       q1;

  logic       req_valid;
  logic [1:0] req_dir;
  logic [1:0] ref_dir;
  logic       legal;
  logic       wrap;
  logic       step_en;
  logic       do_pop;
  logic       do_push;

  // Priority pick and legality of the request against the queue tail / heading
  always_comb begin
    req_valid = bus.BtnUp | bus.BtnRight | bus.BtnDown | bus.BtnLeft;
    req_dir   = 2'd3;
    if (bus.BtnUp)         req_dir = 2'd0;
    else if (bus.BtnRight) req_dir = 2'd1;
    else if (bus.BtnDown)  req_dir = 2'd2;

    ref_dir = dir_q;
    if (pending_q == 2'd1)      ref_dir = q0;
    else if (pending_q == 2'd2) ref_dir = q1;

    legal   = req_valid && (req_dir != ref_dir) && ((req_dir ^ ref_dir) != 2'b10);
    wrap    = (count == WRAP_VAL);
    step_en = (state == RUN) && !bus.BtnPause;
    do_pop  = step_en && wrap && (pending_q != 2'd0);
    do_push = step_en && legal && ((pending_q != 2'd2) || do_pop);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      count     <= '0;
      dir_q     <= 2'b01;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      pending_q <= 2'd0;
      q0        <= 2'd0;
      q1        <= 2'd0;
    end else begin
      tick_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= RUN;
            running_q <= 1'b1;
            dir_q     <= req_dir;
            count     <= '0;
            pending_q <= 2'd0;
          end
        end
        RUN: begin
          if (bus.BtnPause) begin
            state     <= PAUSED;
            running_q <= 1'b0;
            paused_q  <= 1'b1;
          end else begin
            count  <= wrap ? '0 : count + CNT_W'(1);
            tick_q <= wrap;
            if (do_pop) dir_q <= q0;
            // Queue update: slot 0 is the head, slot 1 the second entry
            case ({do_pop, do_push})
              2'b10: begin
                q0        <= q1;
                pending_q <= pending_q - 2'd1;
              end
              2'b01: begin
                if (pending_q == 2'd0) q0 <= req_dir;
                else                   q1 <= req_dir;
                pending_q <= pending_q + 2'd1;
              end
              2'b11: begin
                if (pending_q == 2'd1) begin
                  q0 <= req_dir;
                end else begin
                  q0 <= q1;
                  q1 <= req_dir;
                end
              end
              default: ;
            endcase
          end
        end
        PAUSED: begin
          if (bus.BtnPause) begin
            state     <= RUN;
            running_q <= 1'b1;
            paused_q  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          running_q <= 1'b0;
          paused_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Direction = dir_q;
  assign bus.Tick      = tick_q;
  assign bus.Running   = running_q;
  assign bus.Paused    = paused_q;
  assign bus.Pending   = pending_q;

endmodule

// File: tb/tb_direction_arbiter.sv
// Directed bench for direction_arbiter with TICK_DIV=4 and hand-computed expectations.
module tb_direction_arbiter;

  localparam logic [4:0] B_UP    = 5'b00001;
  localparam logic [4:0] B_RIGHT = 5'b00010;
  localparam logic [4:0] B_DOWN  = 5'b00100;
  localparam logic [4:0] B_LEFT  = 5'b01000;
  localparam logic [4:0] B_PAUSE = 5'b10000;

  logic Clock;
  logic Reset;
  int   n_checks;
  int   n_errs;

  direction_arbiter_if bus ();

  direction_arbiter #(.TICK_DIV(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_btn(input logic [4:0] b);
    bus.BtnUp    = b[0];
    bus.BtnRight = b[1];
    bus.BtnDown  = b[2];
    bus.BtnLeft  = b[3];
    bus.BtnPause = b[4];
  endtask

  task automatic press(input logic [4:0] b);
    set_btn(b);
    step();
    set_btn(5'b0);
  endtask

  // Steps until Tick is seen; the edge count must match the expected latency
  task automatic wait_tick(input string tag, input int exp_edges);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.Tick && n < 20);
    check_eq(tag, 32'(n), 32'(exp_edges));
  endtask

  task automatic check_status(input string tag, input logic [1:0] dir, input logic tick,
                              input logic run, input logic pau, input logic [1:0] pend);
    check_eq({tag, ".dir"},  32'(bus.Direction), 32'(dir));
    check_eq({tag, ".tick"}, 32'(bus.Tick),      32'(tick));
    check_eq({tag, ".run"},  32'(bus.Running),   32'(run));
    check_eq({tag, ".pau"},  32'(bus.Paused),    32'(pau));
    check_eq({tag, ".pend"}, 32'(bus.Pending),   32'(pend));
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    Reset    = 1'b1;
    set_btn(5'b0);
    step();
    step();
    check_status("reset", 2'b01, 1'b0, 1'b0, 1'b0, 2'd0);

    // Press during reset is ignored
    press(B_UP);
    check_status("btn_in_reset", 2'b01, 1'b0, 1'b0, 1'b0, 2'd0);
    Reset = 1'b0;
    step();

    // Pause ignored in IDLE
    press(B_PAUSE);
    check_status("idle_pause", 2'b01, 1'b0, 1'b0, 1'b0, 2'd0);

    // Start: Up loads direction, ticks every 4 cycles
    press(B_UP);
    check_status("start", 2'b00, 1'b0, 1'b1, 1'b0, 2'd0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check_eq($sformatf("tick_cad%0d", i), 32'(bus.Tick), 32'((i % 4) == 0));
    end

    // Turn right to reach heading 01
    press(B_RIGHT);
    check_eq("q_right.pend", 32'(bus.Pending), 32'd1);
    wait_tick("q_right.lat", 3);
    check_status("q_right.tick", 2'b01, 1'b1, 1'b1, 1'b0, 2'd0);

    // Up then Left: Left checked against tail Up, both queued
    press(B_UP);
    press(B_LEFT);
    check_eq("up_left.pend", 32'(bus.Pending), 32'd2);
    wait_tick("up_left.lat1", 2);
    check_status("up_left.t1", 2'b00, 1'b1, 1'b1, 1'b0, 2'd1);
    wait_tick("up_left.lat2", 4);
    check_status("up_left.t2", 2'b11, 1'b1, 1'b1, 1'b0, 2'd0);

    // Back to heading 01 via Up, Right
    press(B_UP);
    press(B_RIGHT);
    wait_tick("back.lat1", 2);
    check_eq("back.dir1", 32'(bus.Direction), 32'd0);
    wait_tick("back.lat2", 4);
    check_status("back.t2", 2'b01, 1'b1, 1'b1, 1'b0, 2'd0);

    // Reversal and same-direction requests are dropped
    press(B_LEFT);
    check_eq("rev.pend", 32'(bus.Pending), 32'd0);
    press(B_RIGHT);
    check_eq("same.pend", 32'(bus.Pending), 32'd0);
    wait_tick("rev.lat1", 2);
    check_eq("rev.dir1", 32'(bus.Direction), 32'd1);
    wait_tick("rev.lat2", 4);
    check_eq("rev.dir2", 32'(bus.Direction), 32'd1);

    // Heading 00, then Right+Left together: only Right queued
    press(B_UP);
    wait_tick("to_up.lat", 3);
    check_eq("to_up.dir", 32'(bus.Direction), 32'd0);
    press(B_RIGHT | B_LEFT);
    check_eq("prio.pend", 32'(bus.Pending), 32'd1);
    wait_tick("prio.lat", 3);
    check_status("prio.tick", 2'b01, 1'b1, 1'b1, 1'b0, 2'd0);

    // Full queue: push dropped, but accepted on a coincident pop
    press(B_DOWN);
    press(B_LEFT);
    check_eq("full.pend2", 32'(bus.Pending), 32'd2);
    press(B_UP);
    check_eq("full.drop", 32'(bus.Pending), 32'd2);
    check_eq("full.notick", 32'(bus.Tick), 32'd0);
    press(B_UP);
    check_status("full.poppush", 2'b10, 1'b1, 1'b1, 1'b0, 2'd2);
    wait_tick("full.lat1", 4);
    check_status("full.t1", 2'b11, 1'b1, 1'b1, 1'b0, 2'd1);
    wait_tick("full.lat2", 4);
    check_status("full.t2", 2'b00, 1'b1, 1'b1, 1'b0, 2'd0);

    // Pause in the wrap cycle: no tick, counter held at wrap value
    step();
    step();
    step();
    press(B_PAUSE | B_RIGHT);
    check_status("pause", 2'b00, 1'b0, 1'b0, 1'b1, 2'd0);
    for (int i = 0; i < 10; i++) begin
      press(((i % 2) != 0) ? B_LEFT : B_RIGHT);
      check_eq($sformatf("hold%0d.tick", i), 32'(bus.Tick), 32'd0);
      check_eq($sformatf("hold%0d.pend", i), 32'(bus.Pending), 32'd0);
    end
    check_status("hold.end", 2'b00, 1'b0, 1'b0, 1'b1, 2'd0);
    press(B_PAUSE);
    check_status("resume", 2'b00, 1'b0, 1'b1, 1'b0, 2'd0);
    step();
    check_eq("resume.tick", 32'(bus.Tick), 32'd1);

    // Fill queue, pause/resume keeps it, then reset at a wrap edge
    press(B_RIGHT);
    press(B_DOWN);
    check_eq("pre_rst.pend", 32'(bus.Pending), 32'd2);
    press(B_PAUSE);
    step();
    check_eq("paused.pend", 32'(bus.Pending), 32'd2);
    check_eq("paused.pau", 32'(bus.Paused), 32'd1);
    press(B_PAUSE);
    step();
    check_status("pre_rst", 2'b00, 1'b0, 1'b1, 1'b0, 2'd2);
    Reset = 1'b1;
    set_btn(B_DOWN);
    step();
    Reset = 1'b0;
    set_btn(5'b0);
    check_status("mid_rst", 2'b01, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) step();
    check_status("post_rst", 2'b01, 1'b0, 1'b0, 1'b0, 2'd0);
    press(B_DOWN);
    check_status("restart", 2'b10, 1'b0, 1'b1, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/direction_arbiter.md
DIRECTION_ARBITER -- requirements
Module: direction_arbiter

Interface
REQ-001 Parameter TICK_DIV, default 25000000, game-step period in Clock cycles, legal range 2..2^32-1.
REQ-002 Clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 BtnUp, BtnRight, BtnDown, BtnLeft  input  1 each  single-cycle press pulses, already debounced and edge-detected upstream.
REQ-005 BtnPause  input  1  single-cycle pause/resume pulse.
REQ-006 Direction  output  2  committed heading: 00 up, 01 right, 10 down, 11 left; registered.
REQ-007 Tick  output  1  one-cycle game-step pulse; registered.
REQ-008 Running  output  1  high in RUN state; registered.
REQ-009 Paused  output  1  high in PAUSED state; registered.
REQ-010 Pending  output  2  current request-queue occupancy, 0..2; registered.

Function
REQ-011 The block SHALL implement three states: IDLE, RUN, PAUSED; Running=(state==RUN), Paused=(state==PAUSED).
REQ-012 Arbitration: more than one direction pulse in a cycle -> only the highest-priority one is considered (Up > Right > Down > Left); the others are discarded.
REQ-013 IDLE: the arbitrated direction pulse SHALL load Direction directly and enter RUN on the same edge, with the tick counter at 0 and the queue empty; reversal rules do not apply in IDLE; BtnPause is ignored in IDLE.
REQ-014 RUN: 32-bit counter increments each cycle; on the edge where counter==TICK_DIV-1 it SHALL return to 0 and Tick SHALL be 1 for exactly the following cycle.
REQ-015 RUN: first Tick appears TICK_DIV cycles after the IDLE->RUN edge; subsequent Ticks every TICK_DIV cycles.
REQ-016 Queue: 2-entry FIFO of requested directions, RUN state only.
REQ-017 Reference heading = queue tail if Pending>0, else Direction (pre-edge values).
REQ-018 In RUN, an arbitrated request SHALL be pushed only if it differs from the reference heading and is not its opposite (XOR of codes != 2'b10); otherwise it is dropped.
REQ-019 Push when Pending==2 SHALL be dropped, unless a pop occurs on the same edge, in which case the push is accepted and Pending stays 2.
REQ-020 On the tick edge (REQ-014) with Pending>0, Direction SHALL take the queue head and the head is popped; Direction's new value is therefore visible in the same cycle Tick is high.
REQ-021 Tick edge with Pending==0: Direction unchanged.
REQ-022 RUN + BtnPause -> PAUSED; counter and queue held; any direction pulse in that cycle is discarded.
REQ-023 PAUSED: no Ticks, counter frozen, direction pulses discarded; BtnPause -> RUN, counter resumes from its held value.
REQ-024 BtnPause takes precedence over a coincident counter wrap: no Tick, no pop, counter holds at TICK_DIV-1.
REQ-025 There SHALL be no return to IDLE except through Reset.

Reset
REQ-026 Reset high at a rising edge SHALL set state=IDLE, Direction=01, Tick=0, Running=0, Paused=0, Pending=0, counter=0, and discard all queue contents, overriding every other input that cycle.
REQ-027 Reset asserted mid-RUN or mid-PAUSED SHALL have the same effect, with no Tick emitted in the cycle after the reset edge.
REQ-028 Button pulses coincident with Reset are ignored.

Verification (TICK_DIV=4)
REQ-029 Reset, then BtnUp pulse -> Direction=00 and Running=1 next cycle; Tick high 4 cycles after that edge and every 4 cycles thereafter.
REQ-030 RUN with Direction=01; pulse BtnUp, then BtnLeft -> Pending=2 (BtnLeft is checked against tail Up, so it is legal); next Tick Direction=00; following Tick Direction=11; Pending=0.
REQ-031 RUN with Direction=01, queue empty; pulse BtnLeft, then BtnRight -> both dropped, Pending=0; Direction stays 01 across Ticks.
REQ-032 RUN with Direction=00; BtnRight and BtnLeft in the same cycle -> only Right queued (Pending=1); next Tick Direction=01.
REQ-033 BtnPause in the wrap cycle -> no Tick, Paused=1; hold 10 cycles with no Tick and direction pulses ignored; BtnPause -> first Tick exactly 1 cycle after resume.
REQ-034 Pending=2 in RUN; assert Reset -> all outputs at reset values next cycle (Direction=01), no Tick; next BtnDown -> Direction=10, Running=1.
